// File: rtl/bp_fe_mock_mem_pkg.sv
// Shared BedRock memory-interface types and the processor configuration used by
// the I-cache mock memory: message types, header layout and byte-lane helpers.
package bp_fe_mock_mem_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   localparam int paddr_width_gp      = 40;
   localparam int cce_block_width_gp  = 512;
   localparam int lce_id_width_gp     = 4;
   localparam int lce_assoc_gp        = 8;
   localparam int block_bytes_gp      = cce_block_width_gp / 8;
   localparam int block_off_width_gp  = $clog2(block_bytes_gp);

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [lce_id_width_gp-1:0]      lce_id;
      logic [$clog2(lce_assoc_gp)-1:0] way_id;
      logic                            prefetch;
      logic                            uncached;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s   payload;
      bp_bedrock_msg_size_e      size;
      logic [paddr_width_gp-1:0] addr;
      bp_bedrock_mem_type_e      msg_type;
   } bp_bedrock_mem_header_s;

   localparam int mem_header_width_gp  = $bits(bp_bedrock_mem_header_s);
   localparam int cce_mem_msg_width_gp = mem_header_width_gp + cce_block_width_gp;

   typedef struct packed {
      bp_bedrock_mem_header_s        header;
      logic [cce_block_width_gp-1:0] data;
   } bp_bedrock_mem_msg_s;

   function automatic int unsigned param_block_width(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return cce_block_width_gp;
         default:          return cce_block_width_gp;
      endcase
   endfunction

   // Sizes larger than one block behave as a full-block access.
   function automatic logic [2:0] eff_size(bp_bedrock_msg_size_e s);
      if (int'(s) > block_off_width_gp) return 3'(block_off_width_gp);
      else return s;
   endfunction

   function automatic logic [block_off_width_gp-1:0] aligned_off(
      logic [block_off_width_gp-1:0] off, bp_bedrock_msg_size_e s);
      logic [block_off_width_gp-1:0] m;
      m = {block_off_width_gp{1'b1}} << eff_size(s);
      return off & m;
   endfunction

   function automatic logic [block_bytes_gp-1:0] size_mask(bp_bedrock_msg_size_e s);
      int unsigned n;
      n = 1 << eff_size(s);
      return ~({block_bytes_gp{1'b1}} << n);
   endfunction

   function automatic logic [cce_block_width_gp-1:0] bit_mask(bp_bedrock_msg_size_e s);
      int unsigned n;
      n = 1 << eff_size(s);
      return ~({cce_block_width_gp{1'b1}} << (n * 8));
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with byte-enable writes; read data appears the
// cycle after a read request and holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
   parameter  int els_p         = 1024,
   parameter  int data_width_p  = 512,
   localparam int addr_width_lp = $clog2(els_p),
   localparam int mask_width_lp = data_width_p / 8
) (
   input  logic                     clk_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [data_width_p-1:0]  data_i,
   input  logic [mask_width_lp-1:0] write_mask_i,
   output logic [data_width_p-1:0]  data_o
);

   logic [data_width_p-1:0] mem_q [els_p];
   logic [data_width_p-1:0] rd_data_q, rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (v_i && !w_i) rd_data_d = mem_q[addr_i];
   end

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      rd_data_q <= rd_data_d;
      if (v_i && w_i) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            if (write_mask_i[b]) mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
         end
      end
   end

   assign data_o = rd_data_q;

endmodule

// File: rtl/bp_fe_mock_mem.sv
// Memory-side responder for the I-cache UCE: one outstanding command, fixed
// latency, response held until yumi. Handshakes: command is taken when
// mem_cmd_v_i & mem_cmd_ready_o; response is consumed when mem_resp_v_o & mem_resp_yumi_i.
module bp_fe_mock_mem
   import bp_fe_mock_mem_pkg::*;
#(
   parameter  bp_params_e bp_params_p     = e_bp_default_cfg,
   parameter  int mem_els_p               = 1024,
   parameter  int latency_p               = 4,
   localparam int cce_mem_msg_width_lp    = cce_mem_msg_width_gp
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
   input  logic                            mem_cmd_v_i,
   output logic                            mem_cmd_ready_o,
   output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
   output logic                            mem_resp_v_o,
   input  logic                            mem_resp_yumi_i
);

   localparam int cce_block_width_lp = param_block_width(bp_params_p);
   localparam int idx_width_lp       = $clog2(mem_els_p);
   // latency_p is legal from 2 to 255; the first delay cycle is implicit.
   localparam logic [7:0] delay_init_lp = 8'(latency_p - 2);

   typedef enum logic [1:0] {e_ready, e_delay, e_resp} state_e;

   bp_bedrock_mem_msg_s cmd_msg;
   assign cmd_msg = bp_bedrock_mem_msg_s'(mem_cmd_i);

   state_e                        state_q, state_d;
   logic [7:0]                    cnt_q, cnt_d;
   logic                          ready_q, ready_d;
   logic                          resp_v_q, resp_v_d;
   logic                          cap_q, cap_d;
   bp_bedrock_mem_header_s        hdr_q, hdr_d;
   logic [cce_block_width_lp-1:0] data_q, data_d;

   logic                          accept, cmd_is_wr, cmd_is_rd;
   logic [block_off_width_gp-1:0] cmd_off, rsp_off;
   logic                          mem_v;
   logic [idx_width_lp-1:0]       mem_addr;
   logic [cce_block_width_lp-1:0] mem_wdata, mem_rdata;
   logic [block_bytes_gp-1:0]     mem_wmask;

   // Outputs are forced quiet for the whole reset cycle, not only after the edge.
   assign mem_cmd_ready_o = ready_q & ~reset_i;
   assign mem_resp_v_o    = resp_v_q & ~reset_i;
   assign mem_resp_o      = reset_i ? '0 : {hdr_q, data_q};

   assign accept    = mem_cmd_v_i & mem_cmd_ready_o;
   assign cmd_is_wr = cmd_msg.header.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};
   assign cmd_is_rd = cmd_msg.header.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
   assign cmd_off   = aligned_off(cmd_msg.header.addr[block_off_width_gp-1:0], cmd_msg.header.size);
   assign rsp_off   = aligned_off(hdr_q.addr[block_off_width_gp-1:0], hdr_q.size);

   // Upper address bits are dropped, so the block index wraps.
   assign mem_v     = accept & (cmd_is_wr | cmd_is_rd);
   assign mem_addr  = cmd_msg.header.addr[block_off_width_gp +: idx_width_lp];
   assign mem_wmask = size_mask(cmd_msg.header.size) << cmd_off;
   assign mem_wdata = cmd_msg.data << {cmd_off, 3'b000};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      resp_v_d = resp_v_q;
      cap_d    = 1'b0;
      hdr_d    = hdr_q;
      data_d   = data_q;

      if (cap_q) begin
         case (hdr_q.msg_type)
            e_bedrock_mem_rd:    data_d = mem_rdata;
            e_bedrock_mem_uc_rd: data_d = (mem_rdata >> {rsp_off, 3'b000}) & bit_mask(hdr_q.size);
            default:             data_d = '0;
         endcase
      end

      case (state_q)
         e_ready: begin
            if (accept) begin
               state_d = e_delay;
               cnt_d   = delay_init_lp;
               ready_d = 1'b0;
               cap_d   = 1'b1;
               hdr_d   = cmd_msg.header;
            end
         end
         e_delay: begin
            if (cnt_q == '0) begin
               state_d  = e_resp;
               resp_v_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         e_resp: begin
            if (mem_resp_yumi_i) begin
               state_d  = e_ready;
               resp_v_d = 1'b0;
               ready_d  = 1'b1;
            end
         end
         default: state_d = e_ready;
      endcase
   end

   // ready_q resets high; the reset_i gate on the port keeps it low until release.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= e_ready;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         resp_v_q <= 1'b0;
         cap_q    <= 1'b0;
         hdr_q    <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         resp_v_q <= resp_v_d;
         cap_q    <= cap_d;
         hdr_q    <= hdr_d;
         data_q   <= data_d;
      end
   end

   bsg_mem_1rw_sync_mask_write_byte #(
      .els_p        (mem_els_p),
      .data_width_p (cce_block_width_lp)
   ) mem (
      .clk_i        (clk_i),
      .v_i          (mem_v),
      .w_i          (cmd_is_wr),
      .addr_i       (mem_addr),
      .data_i       (mem_wdata),
      .write_mask_i (mem_wmask),
      .data_o       (mem_rdata)
   );

endmodule

// File: tb/tb_bp_fe_mock_mem.sv
// Directed bench for bp_fe_mock_mem: writes, reads, size/alignment, hold,
// back-to-back spacing, wrap-around and mid-transaction reset.
module tb_bp_fe_mock_mem;
   import bp_fe_mock_mem_pkg::*;

   localparam int W      = cce_mem_msg_width_gp;
   localparam int D      = cce_block_width_gp;
   localparam int lat_lp = 4;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b1;
   logic [W-1:0] mem_cmd_i = '0;
   logic         mem_cmd_v_i = 1'b0;
   logic         mem_cmd_ready_o;
   logic [W-1:0] mem_resp_o;
   logic         mem_resp_v_o;
   logic         mem_resp_yumi_i = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [W-1:0] exp_q[$];

   // clock / reset block
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   bp_fe_mock_mem #(
      .bp_params_p (e_bp_default_cfg),
      .mem_els_p   (1024),
      .latency_p   (lat_lp)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .mem_cmd_i       (mem_cmd_i),
      .mem_cmd_v_i     (mem_cmd_v_i),
      .mem_cmd_ready_o (mem_cmd_ready_o),
      .mem_resp_o      (mem_resp_o),
      .mem_resp_v_o    (mem_resp_v_o),
      .mem_resp_yumi_i (mem_resp_yumi_i)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [W-1:0] mk(bp_bedrock_mem_type_e t, logic [39:0] a,
                                       bp_bedrock_msg_size_e s, logic [D-1:0] d);
      bp_bedrock_mem_msg_s m;
      m = '0;
      m.header.msg_type       = t;
      m.header.addr           = a;
      m.header.size           = s;
      m.header.payload.lce_id = 4'h3;
      m.header.payload.way_id = 3'h5;
      m.header.payload.uncached = 1'b1;
      m.data = d;
      return m;
   endfunction

   function automatic logic [W-1:0] exp_resp(logic [W-1:0] cmd, logic [D-1:0] d);
      bp_bedrock_mem_msg_s m;
      m = bp_bedrock_mem_msg_s'(cmd);
      m.data = d;
      return m;
   endfunction

   // driver: issue one command, check latency/response/hold, then yumi
   task automatic xact(input logic [W-1:0] cmd, input logic [D-1:0] exp_data,
                       input int hold, input bit early_yumi, output int t_acc);
      int n;
      logic [W-1:0] exp_r;
      t_acc = cyc;
      mem_cmd_i = cmd;
      mem_cmd_v_i = 1'b1;
      n = 0;
      while (mem_cmd_ready_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", mem_cmd_ready_o, 1);
         mem_cmd_v_i = 1'b0;
         return;
      end
      t_acc = cyc;
      tick();
      mem_cmd_v_i = 1'b0;
      mem_cmd_i = ~cmd;
      exp_q.push_back(exp_resp(cmd, exp_data));
      chk("ready_in_delay", mem_cmd_ready_o, 0);
      n = 0;
      while (mem_resp_v_o !== 1'b1 && n < 50) begin
         mem_resp_yumi_i = early_yumi;
         tick();
         n++;
      end
      mem_resp_yumi_i = 1'b0;
      if (n >= 50) begin
         chk("resp_timeout", mem_resp_v_o, 1);
         void'(exp_q.pop_front());
         return;
      end
      chk("latency", W'(cyc - t_acc), W'(lat_lp));
      exp_r = exp_q.pop_front();
      chk("resp", mem_resp_o, exp_r);
      if (hold > 0) begin
         mem_cmd_i = mk(e_bedrock_mem_rd, 40'h80_0000_0040, e_bedrock_msg_size_64, '0);
         mem_cmd_v_i = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_v", mem_resp_v_o, 1);
            chk("hold_data", mem_resp_o, exp_r);
            chk("hold_ready", mem_cmd_ready_o, 0);
         end
         mem_cmd_v_i = 1'b0;
      end
      chk("yumi_cycle_ready", mem_cmd_ready_o, 0);
      mem_resp_yumi_i = 1'b1;
      tick();
      mem_resp_yumi_i = 1'b0;
      chk("post_yumi_v", mem_resp_v_o, 0);
      chk("post_yumi_ready", mem_cmd_ready_o, 1);
   endtask

   logic [D-1:0] p0, pa, pb, blk, blk2;
   int ta, tb, tx;

   initial begin
      p0 = {8{64'h0123_4567_89AB_CDEF}};
      pa = {64{8'h3C}};
      pb = {16{32'hCAFE_F00D}};

      // reset state
      reset_i = 1'b1;
      repeat (3) tick();
      chk("rst_ready", mem_cmd_ready_o, 0);
      chk("rst_resp_v", mem_resp_v_o, 0);
      chk("rst_resp", mem_resp_o, '0);
      reset_i = 1'b0;
      #1;
      chk("ready_after_reset", mem_cmd_ready_o, 1);

      // full-block write, then 8-byte uncached write with junk above the low 8 bytes
      xact(mk(e_bedrock_mem_wr, 40'h80_0000_0000, e_bedrock_msg_size_64, p0), '0, 0, 1'b0, tx);
      xact(mk(e_bedrock_mem_uc_wr, 40'h80_0000_0008, e_bedrock_msg_size_8,
              {{7{64'hFFFF_0000_FFFF_0000}}, 64'h1122_3344_5566_7788}), '0, 0, 1'b1, tx);
      blk = p0;
      blk[127:64] = 64'h1122_3344_5566_7788;

      // back-to-back reads: spacing latency+1, in-order responses
      xact(mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), blk, 0, 1'b0, ta);
      xact(mk(e_bedrock_mem_uc_rd, 40'h80_0000_000A, e_bedrock_msg_size_2, '0), D'(16'h5566), 0, 1'b0, tb);
      chk("spacing", W'(tb - ta), W'(lat_lp + 1));
      xact(mk(e_bedrock_mem_uc_rd, 40'h80_0000_000B, e_bedrock_msg_size_2, '0), D'(16'h5566), 0, 1'b0, ta);
      chk("spacing2", W'(ta - tb), W'(lat_lp + 1));
      xact(mk(e_bedrock_mem_uc_rd, 40'h80_0000_000C, e_bedrock_msg_size_4, '0), D'(32'h1122_3344), 0, 1'b0, tx);
      xact(mk(e_bedrock_mem_uc_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), blk, 0, 1'b0, tx);

      // response held while yumi is low
      xact(mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), blk, 10, 1'b0, tx);

      // cached 4-byte write, misaligned address aligns down to offset 4
      xact(mk(e_bedrock_mem_wr, 40'h80_0000_0005, e_bedrock_msg_size_4, D'(32'hDEAD_BEEF)), '0, 0, 1'b0, tx);
      blk2 = blk;
      blk2[63:32] = 32'hDEAD_BEEF;
      xact(mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), blk2, 0, 1'b0, tx);

      // wrap-around: 1024 blocks * 64 bytes = 0x10000
      xact(mk(e_bedrock_mem_wr, 40'h80_0000_0000, e_bedrock_msg_size_64, pa), '0, 0, 1'b0, tx);
      xact(mk(e_bedrock_mem_wr, 40'h80_0001_0000, e_bedrock_msg_size_64, pb), '0, 0, 1'b0, tx);
      xact(mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), pb, 0, 1'b0, tx);

      // unsupported type: zero data, no storage change
      xact(mk(e_bedrock_mem_pre, 40'h80_0000_0000, e_bedrock_msg_size_64, pa), '0, 0, 1'b0, tx);
      xact(mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), pb, 0, 1'b0, tx);
      xact(mk(e_bedrock_mem_uc_rd, 40'h80_0000_0001, e_bedrock_msg_size_1, '0), D'(8'hF0), 0, 1'b0, tx);

      // reset two cycles after accept
      mem_cmd_i = mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0);
      mem_cmd_v_i = 1'b1;
      chk("pre_reset_ready", mem_cmd_ready_o, 1);
      tick();
      mem_cmd_v_i = 1'b0;
      tick();
      reset_i = 1'b1;
      #1;
      chk("mid_rst_ready", mem_cmd_ready_o, 0);
      tick();
      reset_i = 1'b0;
      #1;
      chk("ready_after_mid_reset", mem_cmd_ready_o, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("no_late_resp", mem_resp_v_o, 0);
      end

      // reset while the response is waiting
      mem_cmd_v_i = 1'b1;
      tick();
      mem_cmd_v_i = 1'b0;
      repeat (3) tick();
      chk("resp_before_reset", mem_resp_v_o, 1);
      reset_i = 1'b1;
      #1;
      chk("resp_v_in_reset", mem_resp_v_o, 0);
      tick();
      reset_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_resp_after_reset", mem_resp_v_o, 0);
      end

      // storage survives reset
      xact(mk(e_bedrock_mem_rd, 40'h80_0000_0000, e_bedrock_msg_size_64, '0), pb, 0, 1'b0, tx);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
